start_token_srl_fifo: RTL

- Control and storage wrapper for the SRL-based start-token FIFO between two dataflow processes, e.g. the linear-layer loader and the PE_i4xi4 pack stage.
- Holds tokens in an internal shift register: a push shifts all entries up by one and writes index 0; a combinational read port is addressed by occupancy.
- Generates the full_n/empty_n handshakes, an occupancy count and an almost-full flag so the producer can throttle early.

---
 rtl/start_token_srl_fifo.sv | 93 +++++++++
 1 files changed

// File: rtl/start_token_srl_fifo.sv
// SRL-style start-token FIFO: shift-register storage read at occupancy-1,
// with registered full/empty/almost-full handshakes and occupancy count.
module start_token_srl_fifo #(
   parameter int unsigned DATA_WIDTH   = 1,
   parameter int unsigned ADDR_WIDTH   = 1,
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  almost_full
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_n_q, full_n_d;
   logic                  empty_n_q, empty_n_d;
   logic                  afull_q, afull_d;
   logic                  push, pop;
   logic [ADDR_WIDTH-1:0] raddr;

   // Handshake qualification uses the registered flags only.
   always_comb begin
      push = if_write & if_write_ce & full_n_q;
      pop  = if_read & if_read_ce & empty_n_q;
   end

   // Shift-in storage: newest at index 0, oldest at count-1.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push) begin
         mem_d[0] = if_din;
         for (int i = 1; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_n_d  = (count_d != CNT_W'(DEPTH));
      empty_n_d = (count_d != CNT_W'(0));
      afull_d   = (count_d >= CNT_W'(AFULL_THRESH));
   end

   // Data path carries no reset; contents are meaningless until written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         full_n_q  <= 1'b1;
         empty_n_q <= 1'b0;
         afull_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         full_n_q  <= full_n_d;
         empty_n_q <= empty_n_d;
         afull_q   <= afull_d;
      end
   end

   always_comb begin
      raddr       = ADDR_WIDTH'(count_q - CNT_W'(1));
      if_dout     = mem_q[raddr];
      if_full_n   = full_n_q;
      if_empty_n  = empty_n_q;
      count       = count_q;
      almost_full = afull_q;
   end

endmodule
